// File: rtl/haraka_pkg.sv
// haraka_pkg: shared widths, skid FSM states and round beat record for Haraka round stages
package haraka_pkg;
    localparam int HARAKA_STATE_W = 128;
    localparam int HARAKA_RC_W    = 128;
    localparam int HARAKA_TAG_W   = 4;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_t;
    typedef struct packed {
        logic [HARAKA_STATE_W-1:0] state;
        logic [HARAKA_RC_W-1:0]    rc;
        logic [HARAKA_TAG_W-1:0]   tag;
    } round_beat_t;
endpackage

// File: rtl/beat_reg.sv
// beat_reg: enabled register holding one beat, with synchronous clear-to-zero
module beat_reg
    import haraka_pkg::*;
#(
    parameter type T = round_beat_t
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  T     d,
    output T     q
);
    always_ff @(posedge clk)
        if (clr) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/round_skid_reg.sv
// round_skid_reg: two-entry skid stage for Haraka round beats with flop-driven ready and sync flush
module round_skid_reg
    import haraka_pkg::*;
#(
    parameter int STATE_W = HARAKA_STATE_W,
    parameter int RC_W    = HARAKA_RC_W,
    parameter int TAG_W   = HARAKA_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [RC_W-1:0]    in_rc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [RC_W-1:0]    out_rc,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);
    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [RC_W-1:0]    rc;
        logic [TAG_W-1:0]   tag;
    } beat_t;
    skid_state_t state_q, state_d;
    beat_t       in_beat, main_d, main_q, skid_q;
    logic        in_fire, out_fire, main_en, skid_en;
    assign in_ready  = state_q != SKID_FULL;
    assign out_valid = state_q != SKID_EMPTY;
    assign occupancy = 2'(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_beat   = '{state: in_state, rc: in_rc, tag: in_tag};
    assign main_d    = state_q == SKID_FULL ? skid_q : in_beat;
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                main_en = in_fire;
                state_d = in_fire ? SKID_BUSY : SKID_EMPTY;
            end
            SKID_BUSY: begin
                main_en = in_fire & out_fire;
                skid_en = in_fire & ~out_fire;
                state_d = skid_en ? SKID_FULL : (out_fire & ~in_fire) ? SKID_EMPTY : SKID_BUSY;
            end
            SKID_FULL: begin
                main_en = out_fire;
                state_d = out_fire ? SKID_BUSY : SKID_FULL;
            end
            default: state_d = SKID_EMPTY;
        endcase
        // flush only invalidates; held data stays so no datapath reset is needed
        if (flush) begin
            state_d = SKID_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end
    always_ff @(posedge clk)
        if (reset) state_q <= SKID_EMPTY;
        else state_q <= state_d;
    beat_reg #(.T(beat_t)) u_main (.clk(clk), .clr(reset), .en(main_en), .d(main_d), .q(main_q));
    beat_reg #(.T(beat_t)) u_skid (.clk(clk), .clr(reset), .en(skid_en), .d(in_beat), .q(skid_q));
    assign out_state = main_q.state;
    assign out_rc    = main_q.rc;
    assign out_tag   = main_q.tag;
endmodule

// File: tb/tb_round_skid_reg.sv
// tb_round_skid_reg: table vectors, hand sequences and random traffic against a queue scoreboard
module tb_round_skid_reg;
    import haraka_pkg::*;
    logic         clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] in_state = '0, in_rc = '0;
    logic [3:0]   in_tag = '0;
    logic         in_ready, out_valid;
    logic [127:0] out_state, out_rc;
    logic [3:0]   out_tag;
    logic [1:0]   occupancy;
    int           checks = 0, errors = 0;
    round_beat_t  q[$];
    typedef struct {int iv, ordy, fl, tag, occ, ov, otag;} vec_t;
    vec_t         vecs[17];
    round_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_rc(in_rc), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_rc(out_rc), .out_tag(out_tag),
        .occupancy(occupancy)
    );
    always #5 clk = ~clk;
    function automatic void chk(string n, logic [259:0] got, logic [259:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endfunction
    function automatic round_beat_t mk(int t);
        round_beat_t b;
        b.tag   = 4'(t);
        b.state = {32{4'(t)}};
        b.rc    = ~b.state;
        return b;
    endfunction
    task automatic drive(input bit iv, input bit ordy, input bit fl, input round_beat_t b);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_state  = b.state;
        in_rc     = b.rc;
        in_tag    = b.tag;
    endtask
    task automatic step();
        bit ifire, ofire;
        round_beat_t b;
        @(negedge clk);
        chk("occupancy", 260'(occupancy), 260'(q.size()));
        chk("in_ready", 260'(in_ready), 260'(q.size() < 2));
        chk("out_valid", 260'(out_valid), 260'(q.size() != 0));
        if (q.size() != 0) chk("out_beat", {out_state, out_rc, out_tag}, q[0]);
        ifire = in_valid && in_ready;
        ofire = out_valid && out_ready;
        b = '{state: in_state, rc: in_rc, tag: in_tag};
        if (reset) q.delete();
        else begin
            if (ofire) void'(q.pop_front());
            if (flush) q.delete();
            else if (ifire) q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic chk_zero(string n);
        chk({n, " out_valid"}, 260'(out_valid), 260'(0));
        chk({n, " in_ready"}, 260'(in_ready), 260'(1));
        chk({n, " occupancy"}, 260'(occupancy), 260'(0));
        chk({n, " fields"}, {out_state, out_rc, out_tag}, 260'(0));
    endtask
    initial begin
        round_beat_t r;
        vecs[0]  = '{1, 0, 0, 1, 1, 1, 1};
        vecs[1]  = '{1, 0, 0, 2, 2, 1, 1};
        vecs[2]  = '{1, 0, 0, 3, 2, 1, 1};
        vecs[3]  = '{1, 1, 0, 3, 1, 1, 2};
        vecs[4]  = '{1, 1, 0, 3, 1, 1, 3};
        vecs[5]  = '{0, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 5, 1, 1, 5};
        vecs[7]  = '{1, 1, 0, 6, 1, 1, 6};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 7, 1, 1, 7};
        vecs[10] = '{1, 0, 0, 8, 2, 1, 7};
        vecs[11] = '{1, 0, 1, 9, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 10, 1, 1, 10};
        vecs[13] = '{0, 1, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 11, 1, 1, 11};
        vecs[15] = '{1, 1, 1, 12, 0, 0, 0};
        vecs[16] = '{0, 1, 0, 0, 0, 0, 0};
        r.state = {16{8'hA5}};
        r.rc    = {16{8'h5A}};
        r.tag   = 4'hA;
        drive(1, 0, 0, r);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        drive(0, 0, 0, mk(0));
        for (int t = 1; t <= 8; t++) begin
            drive(1, 1, 0, mk(t));
            step();
            chk($sformatf("stream occ %0d", t), 260'(occupancy), 260'(1));
            chk($sformatf("stream tag %0d", t), 260'(out_tag), 260'(t));
        end
        drive(0, 1, 0, mk(0));
        step();
        chk("stream drained", 260'(occupancy), 260'(0));
        foreach (vecs[i]) begin
            drive(vecs[i].iv != 0, vecs[i].ordy != 0, vecs[i].fl != 0, mk(vecs[i].tag));
            step();
            chk($sformatf("vec%0d occ", i), 260'(occupancy), 260'(vecs[i].occ));
            chk($sformatf("vec%0d ov", i), 260'(out_valid), 260'(vecs[i].ov));
            if (vecs[i].ov != 0) chk($sformatf("vec%0d tag", i), 260'(out_tag), 260'(vecs[i].otag));
        end
        drive(1, 0, 0, mk(13));
        step();
        drive(1, 0, 0, mk(14));
        step();
        chk("prefill full", 260'(occupancy), 260'(2));
        reset = 1'b1;
        drive(1, 1, 0, mk(15));
        step();
        reset = 1'b0;
        chk_zero("mid reset");
        for (int c = 0; c < 400; c++) begin
            r.state = {$urandom, $urandom, $urandom, $urandom};
            r.rc    = {$urandom, $urandom, $urandom, $urandom};
            r.tag   = 4'($urandom);
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, r);
            step();
        end
        drive(0, 1, 0, mk(0));
        repeat (3) step();
        chk("final drain", 260'(occupancy), 260'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
